// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: sequences start/data/parity/stop handling beside the edge/bit counter.
// Optional errored-frame counter is built when RX_ERR_CNT_EN is defined (otherwise err_cnt reads 0).
module uart_rx_fsm #(
  parameter int PRESCALE   = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST_n,
  input  logic                        RX_IN,
  input  logic                        PAR_EN,
  input  logic [3:0]                  bit_cnt,
  input  logic [$clog2(PRESCALE)-1:0] edge_cnt,
  input  logic                        strt_glitch,
  input  logic                        par_err,
  input  logic                        stp_err,
  output logic                        cnt_en,
  output logic                        dat_samp_en,
  output logic                        strt_chk_en,
  output logic                        deser_en,
  output logic                        par_chk_en,
  output logic                        stp_chk_en,
  output logic                        data_valid,
  output logic                        par_error,
  output logic                        stp_error,
  output logic [7:0]                  err_cnt
);

  localparam int              EW       = $clog2(PRESCALE);
  localparam logic [EW-1:0]   CHK      = EW'(PRESCALE - 1);
  localparam logic [EW-1:0]   STP      = EW'(PRESCALE / 2 + 2);
  localparam logic [3:0]      LAST_BIT = 4'(DATA_WIDTH);

  if (!(PRESCALE == 8 || PRESCALE == 16 || PRESCALE == 32)) begin : g_bad_prescale
    $error("uart_rx_fsm: PRESCALE must be 8, 16 or 32");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 8) begin : g_bad_width
    $error("uart_rx_fsm: DATA_WIDTH must be 5..8");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic   chk_edge, stp_edge, frame_start;
  logic   par_en_q, par_flag, stp_flag;

  assign chk_edge    = (edge_cnt == CHK);
  assign stp_edge    = (edge_cnt == STP);
  assign frame_start = (state == IDLE) && !RX_IN;
  assign dat_samp_en = cnt_en;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_en      = 1'b0;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) state_nxt = START;
      end
      START: begin
        cnt_en = 1'b1;
        if (chk_edge) begin
          strt_chk_en = 1'b1;
          state_nxt   = strt_glitch ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_en = 1'b1;
        if (chk_edge) begin
          deser_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        cnt_en = 1'b1;
        if (chk_edge) begin
          par_chk_en = 1'b1;
          state_nxt  = STOP;
        end
      end
      STOP: begin
        cnt_en = 1'b1;
        // Leave at the majority-vote point so a following start bit is not missed
        if (stp_edge) begin
          stp_chk_en = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      par_en_q   <= 1'b0;
      par_flag   <= 1'b0;
      stp_flag   <= 1'b0;
      data_valid <= 1'b0;
      par_error  <= 1'b0;
      stp_error  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      // Frame configuration and status are fixed at the start edge for the whole frame
      if (frame_start) begin
        par_en_q  <= PAR_EN;
        par_flag  <= 1'b0;
        stp_flag  <= 1'b0;
        par_error <= 1'b0;
        stp_error <= 1'b0;
      end
      if (par_chk_en) par_flag <= par_err;
      if (stp_chk_en) stp_flag <= stp_err;
      if (state == DONE) begin
        data_valid <= ~(par_flag | stp_flag);
        par_error  <= par_flag;
        stp_error  <= stp_flag;
      end
    end
  end

`ifdef RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)                                   err_cnt_q <= 8'd0;
    else if ((state == DONE) && (par_flag | stp_flag)) err_cnt_q <= sat_inc(err_cnt_q);
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: models the edge/bit counter and deserializer around the FSM.
`define CHECK(TAG, OBS, EXP) \
  begin \
    total++; \
    assert ((OBS) === (EXP)) else begin \
      bad++; \
      $error("FAIL %s: observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
  end

module tb_uart_rx_fsm;
  localparam int PRESCALE   = 16;
  localparam int DATA_WIDTH = 8;
  localparam int EW         = $clog2(PRESCALE);
`ifdef RX_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          RX_IN;
  logic          PAR_EN = 1'b0;
  logic [3:0]    bit_cnt;
  logic [EW-1:0] edge_cnt;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic          cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic          data_valid, par_error, stp_error;
  logic [7:0]    err_cnt;

  int total = 0;
  int bad = 0;
  int err_frames = 0;
  int n_deser = 0, n_dv = 0, n_strt = 0, n_par = 0, n_stp = 0;
  int b_deser, b_dv, b_strt, b_par, b_stp;
  int gap;
  logic [7:0]  shreg = 8'h00;
  logic [15:0] frm = 16'hFFFF;
  logic        frm_on = 1'b0;

  uart_rx_fsm #(.PRESCALE(PRESCALE), .DATA_WIDTH(DATA_WIDTH)) dut (
    .CLK(CLK), .RST_n(RST_n), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
    .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err),
    .cnt_en(cnt_en), .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en),
    .deser_en(deser_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid), .par_error(par_error), .stp_error(stp_error),
    .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  // Serial line follows the counter's bit index so each bit lines up with its sampling edge
  always_comb RX_IN = frm_on ? frm[bit_cnt] : 1'b1;

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == EW'(PRESCALE - 1)) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (deser_en) begin
      shreg = {RX_IN, shreg[7:1]};
      n_deser++;
    end
    if (data_valid)  n_dv++;
    if (strt_chk_en) n_strt++;
    if (par_chk_en)  n_par++;
    if (stp_chk_en)  n_stp++;
  end

  task automatic snap();
    b_deser = n_deser; b_dv = n_dv; b_strt = n_strt; b_par = n_par; b_stp = n_stp;
  endtask

  task automatic load(input logic [7:0] d, input logic pe);
    if (pe) frm = {5'h1F, 1'b1, ^d, d, 1'b0};
    else    frm = {6'h3F, 1'b1, d, 1'b0};
  endtask

  task automatic wait_cnt_en(input logic lvl);
    for (int i = 0; i < 400 && cnt_en !== lvl; i++) @(negedge CLK);
    `CHECK("cnt_en_wait", cnt_en, lvl)
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pe, input logic perr,
                           input logic serr, input logic flip);
    PAR_EN = pe; par_err = perr; stp_err = serr; strt_glitch = 1'b0;
    load(d, pe);
    snap();
    frm_on = 1'b1;
    wait_cnt_en(1'b1);
    if (flip) PAR_EN = ~PAR_EN;
    wait_cnt_en(1'b0);
    frm_on = 1'b0;
    repeat (3) @(negedge CLK);
    if (CNT_ON && (perr && pe || serr)) err_frames++;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge CLK);
    `CHECK("rst_strobes", {cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en}, 6'b0)
    `CHECK("rst_flags", {data_valid, par_error, stp_error}, 3'b0)
    `CHECK("rst_err_cnt", err_cnt, 8'd0)
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);
    `CHECK("idle_cnt_en", cnt_en, 1'b0)

    // good frame, no parity; PAR_EN flipped mid-frame must be ignored
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    `CHECK("a5_deser", n_deser - b_deser, 8)
    `CHECK("a5_data", shreg, 8'hA5)
    `CHECK("a5_dv", n_dv - b_dv, 1)
    `CHECK("a5_par_chk", n_par - b_par, 0)
    `CHECK("a5_stp_chk", n_stp - b_stp, 1)
    `CHECK("a5_strt_chk", n_strt - b_strt, 1)
    `CHECK("a5_errs", {par_error, stp_error}, 2'b00)
    `CHECK("a5_err_cnt", err_cnt, 8'(err_frames))

    // parity error frame
    run_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    `CHECK("3c_deser", n_deser - b_deser, 8)
    `CHECK("3c_data", shreg, 8'h3C)
    `CHECK("3c_par_chk", n_par - b_par, 1)
    `CHECK("3c_dv", n_dv - b_dv, 0)
    `CHECK("3c_errs", {par_error, stp_error}, 2'b10)
    `CHECK("3c_err_cnt", err_cnt, 8'(CNT_ON ? 1 : 0))

    // start glitch: line low 4 cycles, checker reports glitch at edge 15
    snap();
    PAR_EN = 1'b0; par_err = 1'b0; strt_glitch = 1'b1;
    frm = 16'h0000; frm_on = 1'b1;
    repeat (4) @(negedge CLK);
    frm_on = 1'b0;
    wait_cnt_en(1'b0);
    repeat (20) @(negedge CLK);
    strt_glitch = 1'b0;
    `CHECK("gl_strt_chk", n_strt - b_strt, 1)
    `CHECK("gl_deser", n_deser - b_deser, 0)
    `CHECK("gl_stp_chk", n_stp - b_stp, 0)
    `CHECK("gl_dv", n_dv - b_dv, 0)
    `CHECK("gl_cnt_en", cnt_en, 1'b0)
    `CHECK("gl_errs", {par_error, stp_error}, 2'b00)
    `CHECK("gl_err_cnt", err_cnt, 8'(err_frames))

    // stop error, held until the next frame starts, then cleared by a good frame
    run_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    `CHECK("stp_dv", n_dv - b_dv, 0)
    `CHECK("stp_errs", {par_error, stp_error}, 2'b01)
    `CHECK("stp_err_cnt", err_cnt, 8'(err_frames))
    repeat (10) @(negedge CLK);
    `CHECK("stp_hold", stp_error, 1'b1)
    run_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
    `CHECK("7e_data", shreg, 8'h7E)
    `CHECK("7e_dv", n_dv - b_dv, 1)
    `CHECK("7e_errs", {par_error, stp_error}, 2'b00)

    // parity and stop errors together
    run_frame(8'h42, 1'b1, 1'b1, 1'b1, 1'b0);
    `CHECK("both_dv", n_dv - b_dv, 0)
    `CHECK("both_errs", {par_error, stp_error}, 2'b11)
    `CHECK("both_err_cnt", err_cnt, 8'(err_frames))

    // back-to-back frames 0x55 then 0xAA with no idle gap
    PAR_EN = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    load(8'h55, 1'b0);
    snap();
    frm_on = 1'b1;
    wait_cnt_en(1'b1);
    wait_cnt_en(1'b0);
    load(8'hAA, 1'b0);
    gap = 0;
    for (int i = 0; i < 10 && cnt_en !== 1'b1; i++) begin
      @(negedge CLK);
      gap++;
    end
    `CHECK("b2b_gap", gap, 2)
    wait_cnt_en(1'b0);
    frm_on = 1'b0;
    repeat (3) @(negedge CLK);
    `CHECK("b2b_deser", n_deser - b_deser, 16)
    `CHECK("b2b_data", shreg, 8'hAA)
    `CHECK("b2b_dv", n_dv - b_dv, 2)
    `CHECK("b2b_stp_chk", n_stp - b_stp, 2)
    `CHECK("b2b_errs", {par_error, stp_error}, 2'b00)

    // asynchronous reset during data bit 4
    load(8'h0F, 1'b0);
    snap();
    frm_on = 1'b1;
    wait_cnt_en(1'b1);
    for (int i = 0; i < 400 && bit_cnt != 4'd4; i++) @(negedge CLK);
    `CHECK("rst_bit4_wait", bit_cnt, 4'd4)
    #2 RST_n = 1'b0;
    #1;
    `CHECK("arst_strobes", {cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en}, 6'b0)
    `CHECK("arst_flags", {data_valid, par_error, stp_error}, 3'b0)
    `CHECK("arst_err_cnt", err_cnt, 8'd0)
    err_frames = 0;
    frm_on = 1'b0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    repeat (3) @(negedge CLK);
    `CHECK("arst_dv", n_dv - b_dv, 0)
    run_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    `CHECK("96_deser", n_deser - b_deser, 8)
    `CHECK("96_data", shreg, 8'h96)
    `CHECK("96_dv", n_dv - b_dv, 1)
    `CHECK("96_errs", {par_error, stp_error}, 2'b00)
    `CHECK("96_err_cnt", err_cnt, 8'd0)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
